multicycle_controller: RTL and testbench

Main control unit for the multicycle RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives the shared ALU, register file, instruction register and unified memory port, and configures the immediate extender through `ImmSrc`. A ready handshake on the memory port lets fetch, load and store stall for any number of cycles.

---
 rtl/multicycle_controller.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives datapath selects, write enables and the retire counter.
module multicycle_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // The only path from DECODE back to FETCH is the illegal-opcode exit, which must not retire.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_DECODE);

  logic       pc_update, branch, alu_decode, alu_sub;
  logic       irw, regw, memw, ill;
  logic [2:0] alu_dec_ctl;

  always_comb begin
    unique case (funct3)
      3'b000:  alu_dec_ctl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_dec_ctl = 3'b101;
      3'b110:  alu_dec_ctl = 3'b011;
      3'b111:  alu_dec_ctl = 3'b010;
      default: alu_dec_ctl = 3'b000;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_decode = 1'b0;
    alu_sub    = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    ill        = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        irw       = mem_ready;
        pc_update = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ill     = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        alu_decode = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        alu_decode = 1'b1;
      end
      S_ALUWB:    regw = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_sub = 1'b1;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign ALUControl = alu_decode ? alu_dec_ctl : (alu_sub ? 3'b001 : 3'b000);

  // State is already FETCH during reset; gating with rst_n keeps FETCH's enables low too.
  assign PCWrite  = rst_n & (pc_update | (branch & zero));
  assign IRWrite  = rst_n & irw;
  assign RegWrite = rst_n & regw;
  assign MemWrite = rst_n & memw;
  assign illegal  = rst_n & ill;
  assign instret  = instret_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random
// instruction streams checked against a per-instruction state-sequence model.
module tb_multicycle_controller;
  localparam int unsigned W = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [6:0] op = LW;
  logic [2:0] funct3 = '0;
  logic funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [W-1:0] instret;
  logic [3:0] state;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_instret = '0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } ent_t;

  always #5 clk = ~clk;

  multicycle_controller #(.INSTRET_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .illegal(illegal), .instret(instret), .state(state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] imm_ref(input logic [6:0] o);
    if (o == SW) return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // {ResultSrc, ALUSrcA, ALUSrcB} per state
  function automatic logic [5:0] sel_ref(input logic [3:0] st);
    case (st)
      4'd0:    return 6'b10_00_10;
      4'd1:    return 6'b00_01_01;
      4'd2:    return 6'b00_10_01;
      4'd4:    return 6'b01_00_00;
      4'd6:    return 6'b00_10_00;
      4'd7:    return 6'b00_10_01;
      4'd9:    return 6'b00_10_00;
      4'd10:   return 6'b00_01_10;
      default: return 6'b00_00_00;
    endcase
  endfunction

  task automatic test_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int unsigned fs, input int unsigned ms);
    ent_t q[$];
    bit legal = 1'b1;
    logic [16:0] exp_v, got_v;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int unsigned i = 0; i < fs; i++) q.push_back('{4'd0, 1'b0});
    q.push_back('{4'd0, 1'b1});
    q.push_back('{4'd1, 1'($urandom_range(0, 1))});
    case (o)
      LW: begin
        q.push_back('{4'd2, 1'($urandom_range(0, 1))});
        for (int unsigned i = 0; i < ms; i++) q.push_back('{4'd3, 1'b0});
        q.push_back('{4'd3, 1'b1});
        q.push_back('{4'd4, 1'($urandom_range(0, 1))});
      end
      SW: begin
        q.push_back('{4'd2, 1'($urandom_range(0, 1))});
        for (int unsigned i = 0; i < ms; i++) q.push_back('{4'd5, 1'b0});
        q.push_back('{4'd5, 1'b1});
      end
      RT: begin q.push_back('{4'd6, 1'($urandom_range(0, 1))}); q.push_back('{4'd8, 1'($urandom_range(0, 1))}); end
      IT: begin q.push_back('{4'd7, 1'($urandom_range(0, 1))}); q.push_back('{4'd8, 1'($urandom_range(0, 1))}); end
      BEQ: q.push_back('{4'd9, 1'($urandom_range(0, 1))});
      JAL: begin q.push_back('{4'd10, 1'($urandom_range(0, 1))}); q.push_back('{4'd8, 1'($urandom_range(0, 1))}); end
      default: legal = 1'b0;
    endcase
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      #1;
      checks++;
      if (state !== q[i].st)
        $display("FAIL state op=%b cyc%0d: got %0d want %0d", o, i, state, q[i].st);
      else passes++;
      exp_v = {(q[i].st == 0 && q[i].rdy) || (q[i].st == 9 && z) || q[i].st == 10,
               q[i].st == 3 || q[i].st == 5, q[i].st == 5, q[i].st == 0 && q[i].rdy,
               q[i].st == 4 || q[i].st == 8, sel_ref(q[i].st), imm_ref(o),
               (q[i].st == 6 || q[i].st == 7) ? alu_ref(o, f3, f7) : (q[i].st == 9 ? 3'b001 : 3'b000),
               q[i].st == 1 && !legal};
      got_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, illegal};
      checks++;
      if (got_v !== exp_v)
        $display("FAIL controls op=%b st=%0d cyc%0d: got %b want %b", o, q[i].st, i, got_v, exp_v);
      else passes++;
      @(posedge clk);
      @(negedge clk);
    end
    if (legal) exp_instret = exp_instret + 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) $display("FAIL end_state op=%b: got %0d want 0", o, state);
    else passes++;
    checks++;
    if (instret !== exp_instret) $display("FAIL instret op=%b: got %0d want %0d", o, instret, exp_instret);
    else passes++;
  endtask

  task automatic test_reset_initial();
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== {4'd0, 5'b0})
      $display("FAIL reset_outputs: got st=%0d en=%b want st=0 en=00000", state,
               {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
    else passes++;
    checks++;
    if ({ResultSrc, ALUSrcA, ALUSrcB, AdrSrc} !== 7'b10_00_10_0)
      $display("FAIL reset_selects: got %b want 1000100", {ResultSrc, ALUSrcA, ALUSrcB, AdrSrc});
    else passes++;
    checks++;
    if (instret !== '0) $display("FAIL reset_instret: got %0d want 0", instret);
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_store();
    op = SW; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({state, MemWrite} !== {4'd5, 1'b1}) $display("FAIL pre_reset_memwrite: got st=%0d mw=%b want st=5 mw=1", state, MemWrite);
    else passes++;
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_instret = '0;
    checks++;
    if ({state, MemWrite, PCWrite, IRWrite} !== {4'd0, 3'b000})
      $display("FAIL async_reset: got st=%0d mw/pcw/irw=%b want st=0 000", state, {MemWrite, PCWrite, IRWrite});
    else passes++;
    checks++;
    if (instret !== '0) $display("FAIL async_reset_instret: got %0d want 0", instret);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({state, PCWrite, IRWrite} !== {4'd0, 2'b00}) $display("FAIL held_reset: got st=%0d pcw/irw=%b want st=0 00", state, {PCWrite, IRWrite});
    else passes++;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({state, IRWrite, PCWrite} !== {4'd0, 2'b11}) $display("FAIL reset_release: got st=%0d irw/pcw=%b want st=0 11", state, {IRWrite, PCWrite});
    else passes++;
    @(negedge clk);
    // one FETCH cycle consumed with mem_ready=1: finish that instruction as a lw
    op = LW;
    repeat (4) @(negedge clk);
    exp_instret = exp_instret + 1'b1;
    #1;
    checks++;
    if ({state, instret} !== {4'd0, exp_instret}) $display("FAIL post_reset_lw: got st=%0d ir=%0d want st=0 ir=%0d", state, instret, exp_instret);
    else passes++;
  endtask

  task automatic test_lw();        test_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0); endtask
  task automatic test_sw_stall();  test_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3); endtask
  task automatic test_rtype_sub(); test_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0); endtask
  task automatic test_addi();      test_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0); endtask
  task automatic test_beq();
    test_instr(BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    test_instr(BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
  endtask
  task automatic test_jal();       test_instr(JAL, 3'b101, 1'b0, 1'b0, 0, 0); endtask
  task automatic test_illegal();   test_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0); endtask

  task automatic test_random();
    logic [6:0] ops [6] = '{LW, SW, RT, IT, BEQ, JAL};
    logic [6:0] o;
    for (int n = 0; n < 40; n++) begin
      int unsigned pick = $urandom_range(0, 6);
      o = (pick < 6) ? ops[pick] : 7'($urandom);
      test_instr(o, 3'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset_initial();
    test_lw();
    test_sw_stall();
    test_rtype_sub();
    test_addi();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_store();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
